muldiv_control: RTL and testbench
=================================

Name: muldiv_control

Overview:
- Parametrised sequencer for the iterative shift-add multiplier / restoring divider datapath; the next generation of the multiplier Control unit.
- Generalised to WIDTH-bit operands; adds a divide mode with restore cycles and a quotient-bit output.
- Drives the load, ALU, write and shift strobes of the datapath registers; run/ready handshake towards the CPU.

Parameters:
- WIDTH, 32, operand width; iteration count per operation.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- run  input  1  start request; sampled in IDLE or DONE.
- mode  input  1  0 = multiply, 1 = divide; latched when run is accepted.
- lsb  input  1  multiplier LSB from datapath; sampled in OP (multiply).
- rem_sign  input  1  sign of remainder after trial subtraction; sampled in CHECK (divide).
- ready  output  1  operation complete; held until next run.
- busy  output  1  high in LOAD, OP, CHECK, RESTORE, SHIFT.
- wrctrl  output  1  load operands into datapath.
- strctrl  output  1  write ALU result into the product/remainder register.
- addctrl  output  6  ALU operation code to datapath.
- qbit  output  1  quotient bit shifted in during SHIFT (divide), else 0.

Behaviour:
- Reset is synchronous; reset dominates every other input in every state. Reset mid-operation returns to IDLE next edge; the operation is abandoned.
- Reset and IDLE values: every output 0, count = 0, latched mode = 0.
- States: IDLE, LOAD, OP, CHECK, RESTORE, SHIFT, DONE. Outputs are Moore, decoded from state plus latched mode, lsb and rem_sign.
- IDLE: run=1 -> LOAD; latch mode; count <= 0.
- LOAD, one cycle: wrctrl=1 -> OP.
- OP, multiply: strctrl=1; addctrl = ALU_ADD if lsb=1, else ALU_NOP (register rewritten unchanged) -> SHIFT.
- OP, divide: strctrl=1; addctrl = ALU_SUB -> CHECK.
- CHECK, divide only, no strobes: rem_sign=1 -> RESTORE; rem_sign=0 -> SHIFT with qbit=1.
- RESTORE: strctrl=1; addctrl = ALU_ADD -> SHIFT with qbit=0.
- SHIFT: strctrl=0, addctrl=0; qbit driven as decided above; count <= count+1.
  - count+1 == WIDTH -> DONE; otherwise -> OP.
- DONE: ready=1.
  - run=1 -> LOAD directly; ready drops the same edge. This is back-to-back restart; no IDLE visit is needed.
  - run=0 -> stay in DONE.
- Latency from run accepted to ready:
  - Multiply: exactly 1 + 2*WIDTH cycles.
  - Divide: 1 + 3*WIDTH + (number of restores) cycles.
- run while busy is ignored. mode is used only from its latched copy; changes mid-operation have no effect.
- The counter saturates: it never wraps, and it is cleared only in IDLE or on LOAD entry.

Optional Feature:
- Macro MULDIV_CYCLE_CNT_EN.
- Defined: adds output cycles[15:0], counting every busy cycle of the current operation. It clears on LOAD entry, holds its value in DONE, and saturates at 16'hFFFF.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package muldiv_pkg holds:
  - the state enum (7 states, 3-bit);
  - ALU codes ALU_NOP=6'd0, ALU_ADD=6'd27, ALU_SUB=6'd34;
  - MODE_MUL/MODE_DIV constants.
- One sub-module, muldiv_iter_cnt: the CNT_W saturating counter with clear, increment and last-iteration flag (count+1 == WIDTH).
- The FSM and output decode stay in muldiv_control.

Test Plan:
- WIDTH=4, multiply: reset 1 cycle, run pulse 1 cycle, lsb pattern 1,1,0,1 per OP.
  - Required: wrctrl for exactly 1 cycle.
  - Required: addctrl sequence 27,0,27,0,0,0,27,0 across OP/SHIFT.
  - Required: ready=1 on cycle 9 after run accepted, held 20 cycles with run=0.
- WIDTH=4, divide, rem_sign 0,1,0,1.
  - Required: qbit in SHIFT cycles 1,0,1,0.
  - Required: two RESTORE cycles with addctrl=27.
  - Required: ready after 1+12+2=15 cycles.
- Reset asserted in the second OP of a multiply: all outputs 0 next edge; a new run then produces a clean full 9-cycle sequence.
- run held high through DONE: DONE->LOAD restart; ready high for exactly 1 cycle between operations. run toggling while busy has no effect on count or latency.
- Default WIDTH=32 multiply, lsb=1 throughout: 32 ADD cycles; ready exactly 65 cycles after run accepted.
- With MULDIV_CYCLE_CNT_EN, WIDTH=4 divide with 2 restores: cycles=15 in DONE; cycles=0 after reset.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the shift-add multiply / restoring divide sequencer.
package muldiv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_OP      = 3'd2,
      ST_CHECK   = 3'd3,
      ST_RESTORE = 3'd4,
      ST_SHIFT   = 3'd5,
      ST_DONE    = 3'd6
   } state_e;

   localparam logic [5:0] ALU_NOP = 6'd0;
   localparam logic [5:0] ALU_ADD = 6'd27;
   localparam logic [5:0] ALU_SUB = 6'd34;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/muldiv_iter_cnt.sv
// Iteration counter: clear, saturating increment, and a flag on the final iteration.
module muldiv_iter_cnt #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic last
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [CNT_W-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // true while the iteration in flight is the last one, i.e. count+1 == WIDTH
   assign last = (count_q == LAST_CNT);

endmodule

// File: rtl/muldiv_control.sv
// Sequencer for the iterative multiply / restoring divide datapath.
// Optional busy-cycle counter output enabled by defining MULDIV_CYCLE_CNT_EN.
//
// state   | meaning
// IDLE    | waiting for run, counter held clear
// LOAD    | operands written into datapath
// OP      | add (mul, lsb=1) / nop (mul, lsb=0) / subtract (div) into remainder
// CHECK   | divide: inspect remainder sign after trial subtraction
// RESTORE | divide: add divisor back after a negative trial
// SHIFT   | shift datapath, quotient bit presented, iteration counted
// DONE    | ready held until the next run
module muldiv_control
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       mode,
   input  logic       lsb,
   input  logic       rem_sign,
   output logic       ready,
   output logic       busy,
   output logic       wrctrl,
   output logic       strctrl,
   output logic [5:0] addctrl,
   output logic       qbit
`ifdef MULDIV_CYCLE_CNT_EN
   ,
   output logic [15:0] cycles
`endif
);

   state_e state_d, state_q;
   logic   mode_d, mode_q;
   logic   qbit_d, qbit_q;
   logic   cnt_clr, cnt_inc, cnt_last;

   muldiv_iter_cnt #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .last  (cnt_last)
   );

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      qbit_d  = qbit_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      ready   = 1'b0;
      busy    = 1'b0;
      wrctrl  = 1'b0;
      strctrl = 1'b0;
      addctrl = ALU_NOP;
      qbit    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (run) begin
               state_d = ST_LOAD;
               mode_d  = mode;
            end
         end
         ST_LOAD: begin
            busy    = 1'b1;
            wrctrl  = 1'b1;
            qbit_d  = 1'b0;
            state_d = ST_OP;
         end
         ST_OP: begin
            busy    = 1'b1;
            strctrl = 1'b1;
            if (mode_q == MODE_DIV) begin
               addctrl = ALU_SUB;
               state_d = ST_CHECK;
            end else begin
               // NOP still strobes so the register is rewritten unchanged
               addctrl = lsb ? ALU_ADD : ALU_NOP;
               state_d = ST_SHIFT;
            end
         end
         ST_CHECK: begin
            busy = 1'b1;
            if (rem_sign) begin
               state_d = ST_RESTORE;
            end else begin
               qbit_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_RESTORE: begin
            busy    = 1'b1;
            strctrl = 1'b1;
            addctrl = ALU_ADD;
            qbit_d  = 1'b0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            busy    = 1'b1;
            qbit    = (mode_q == MODE_DIV) && qbit_q;
            cnt_inc = 1'b1;
            state_d = cnt_last ? ST_DONE : ST_OP;
         end
         ST_DONE: begin
            ready = 1'b1;
            if (run) begin
               state_d = ST_LOAD;
               mode_d  = mode;
               cnt_clr = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_MUL;
         qbit_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         qbit_q  <= qbit_d;
      end
   end

`ifdef MULDIV_CYCLE_CNT_EN
   logic [15:0] cycles_d, cycles_q;

   // LOAD is only ever entered from IDLE or DONE, so state_d==LOAD marks a new operation
   always_comb begin
      cycles_d = cycles_q;
      if (state_d == ST_LOAD) begin
         cycles_d = 16'd0;
      end else if (busy && (cycles_q != 16'hFFFF)) begin
         cycles_d = cycles_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycles_q <= 16'd0;
      end else begin
         cycles_q <= cycles_d;
      end
   end

   assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_muldiv_control.sv
// Directed self-checking bench for muldiv_control at WIDTH=4 and the default WIDTH=32.
module tb_muldiv_control;
   import muldiv_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       run, mode, lsb, rem_sign;
   logic       ready, busy, wrctrl, strctrl, qbit;
   logic [5:0] addctrl;
`ifdef MULDIV_CYCLE_CNT_EN
   logic [15:0] cycles;
   logic [15:0] w_cycles;
`endif

   logic       w_run, w_mode, w_lsb, w_rem_sign;
   logic       w_ready, w_busy, w_wrctrl, w_strctrl, w_qbit;
   logic [5:0] w_addctrl;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   muldiv_control #(.WIDTH(4)) dut4 (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .mode     (mode),
      .lsb      (lsb),
      .rem_sign (rem_sign),
      .ready    (ready),
      .busy     (busy),
      .wrctrl   (wrctrl),
      .strctrl  (strctrl),
      .addctrl  (addctrl),
      .qbit     (qbit)
`ifdef MULDIV_CYCLE_CNT_EN
      ,
      .cycles   (cycles)
`endif
   );

   muldiv_control dut32 (
      .clk      (clk),
      .reset    (reset),
      .run      (w_run),
      .mode     (w_mode),
      .lsb      (w_lsb),
      .rem_sign (w_rem_sign),
      .ready    (w_ready),
      .busy     (w_busy),
      .wrctrl   (w_wrctrl),
      .strctrl  (w_strctrl),
      .addctrl  (w_addctrl),
      .qbit     (w_qbit)
`ifdef MULDIV_CYCLE_CNT_EN
      ,
      .cycles   (w_cycles)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] pk(input logic b, input logic r, input logic w,
                                      input logic s, input logic q, input logic [5:0] a);
      return {b, r, w, s, q, a};
   endfunction

   function automatic logic [10:0] obs();
      return {busy, ready, wrctrl, strctrl, qbit, addctrl};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // rmode: 0 = single run pulse, 1 = run/mode toggled while busy, 2 = run held high
   task automatic run4(input logic m, input logic [3:0] pat, input int rmode);
      mode = m;
      run  = 1'b1;
      step();
      if (rmode != 2) run = 1'b0;
      chk("load", obs(), pk(1, 0, 1, 0, 0, 6'd0));
      for (int i = 0; i < 4; i++) begin
         lsb      = pat[i];
         rem_sign = pat[i];
         if (rmode == 1) begin
            run  = ~run;
            mode = ~mode;
         end
         step();
         if (m) chk("op_div", obs(), pk(1, 0, 0, 1, 0, 6'd34));
         else   chk("op_mul", obs(), pk(1, 0, 0, 1, 0, pat[i] ? 6'd27 : 6'd0));
         if (m) begin
            step();
            chk("check", obs(), pk(1, 0, 0, 0, 0, 6'd0));
            if (pat[i]) begin
               step();
               chk("restore", obs(), pk(1, 0, 0, 1, 0, 6'd27));
            end
         end
         if (rmode == 1) run = ~run;
         step();
         chk("shift", obs(), pk(1, 0, 0, 0, m & ~pat[i], 6'd0));
      end
      step();
      if (rmode != 2) run = 1'b0;
      chk("done", obs(), pk(0, 1, 0, 0, 0, 6'd0));
   endtask

   initial begin
      int n, adds;
      reset = 1'b1; run = 1'b0; mode = 1'b0; lsb = 1'b0; rem_sign = 1'b0;
      w_run = 1'b0; w_mode = 1'b0; w_lsb = 1'b0; w_rem_sign = 1'b0;
      step();
      run = 1'b1;
      step();
      reset = 1'b0;
      run   = 1'b0;
      chk("reset_outs", obs(), 11'd0);
      chk("reset_w32", {w_busy, w_ready, w_wrctrl, w_strctrl, w_qbit, w_addctrl}, 11'd0);
`ifdef MULDIV_CYCLE_CNT_EN
      chk("reset_cycles", cycles, 16'd0);
`endif

      // multiply, lsb 1,1,0,1; then hold DONE for 20 cycles
      run4(1'b0, 4'b1011, 0);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("done_hold", obs(), pk(0, 1, 0, 0, 0, 6'd0));
      end

      // divide, rem_sign 0,1,0,1: two restores, 15-cycle latency
      do_reset();
      chk("reset2", obs(), 11'd0);
      run4(1'b1, 4'b1010, 0);
`ifdef MULDIV_CYCLE_CNT_EN
      chk("cycles_div", cycles, 16'd15);
      step();
      chk("cycles_hold", cycles, 16'd15);
      do_reset();
      chk("cycles_rst", cycles, 16'd0);
`endif

      // reset in the second OP of a multiply
      mode = 1'b0; lsb = 1'b1; run = 1'b1;
      step();
      run = 1'b0;
      step();
      step();
      step();
      chk("op2_pre_rst", obs(), pk(1, 0, 0, 1, 0, 6'd27));
      reset = 1'b1;
      run   = 1'b1;
      step();
      reset = 1'b0;
      run   = 1'b0;
      chk("mid_reset", obs(), 11'd0);
      step();
      chk("idle_stay", obs(), 11'd0);
      run4(1'b0, 4'b1011, 0);

      // back-to-back restarts with run held, then run/mode toggling while busy
      run4(1'b0, 4'b0110, 2);
      run4(1'b1, 4'b0011, 2);
      run4(1'b0, 4'b1111, 1);
      run4(1'b1, 4'b0101, 1);
      step();
      chk("final_hold", obs(), pk(0, 1, 0, 0, 0, 6'd0));

      // default WIDTH=32 multiply, lsb=1 throughout
      w_lsb = 1'b1; w_mode = 1'b0; w_run = 1'b1;
      step();
      w_run = 1'b0;
      chk("w32_load", {w_busy, w_wrctrl}, 2'b11);
      n = 0;
      adds = 0;
      while (!w_ready && n < 200) begin
         if (w_addctrl == 6'd27) adds++;
         step();
         n++;
      end
      chk("w32_latency", n, 65);
      chk("w32_adds", adds, 32);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
